// File: rtl/framed_seq_detector.sv
// Mealy bit-serial pattern detector: framed or sliding matching against N
// run-time programmable W-bit pattern slots, with a saturating hit counter.
module framed_seq_detector #(
    parameter int W     = 4,
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_idx,
    input  logic [W-1:0]     cfg_pat,
    input  logic             cfg_en,
    input  logic             cnt_clr,
    output logic             dec,
    output logic [1:0]       dec_id,
    output logic [CNT_W-1:0] hit_cnt
);

    // state    | meaning
    // FR_MATCH | framed, at least one slot still matches the frame prefix
    // FR_FAIL  | framed, no slot alive; bits consumed until the frame ends
    // SLIDE    | sliding (overlapping) window matching
    localparam logic [1:0] FR_MATCH = 2'd0;
    localparam logic [1:0] FR_FAIL  = 2'd1;
    localparam logic [1:0] SLIDE    = 2'd2;

    localparam int PW = $clog2(W);

    logic [W-1:0]  pat_q [N];
    logic [N-1:0]  en_q;
    logic [N-1:0]  wr_mask;

    logic [1:0]    state_q, state_d;
    logic          mode_q;
    logic [PW-1:0] pos_q, pos_d;
    logic [N-1:0]  alive_q, alive_d;
    logic [W-2:0]  shreg_q, shreg_d;
    logic [PW-1:0] fill_q, fill_d;

    logic          mode_chg;
    logic          last_bit;
    logic          fill_full;
    logic [PW-1:0] bit_idx;
    logic [W-1:0]  window;
    logic [N-1:0]  base;
    logic [N-1:0]  hit;
    logic [N-1:0]  survive;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            wr_mask[i] = cfg_we && (cfg_idx == 2'(i));
        end
    end

    always_comb begin
        mode_chg  = (mode != mode_q);
        last_bit  = (pos_q == PW'(W - 1));
        fill_full = (fill_q == PW'(W - 1));
        bit_idx   = PW'(W - 1) - pos_q;
        window    = {shreg_q, in};
        if (pos_q == '0) begin
            base = en_q;
        end else if (state_q == FR_FAIL) begin
            base = '0;
        end else begin
            base = alive_q;
        end
        for (int i = 0; i < N; i++) begin
            if (mode_q) begin
                hit[i] = en_q[i] && fill_full && (window == pat_q[i]);
            end else begin
                hit[i] = base[i] && (pat_q[i][bit_idx] == in);
            end
        end
        survive = hit & ~wr_mask;
    end

    // Mealy outputs: a discarded mode-change bit never detects.
    always_comb begin
        dec    = rst_n && in_valid && !mode_chg && (|hit) && (mode_q || last_bit);
        dec_id = '0;
        if (dec) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (hit[i]) begin
                    dec_id = 2'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        alive_d = alive_q;
        shreg_d = shreg_q;
        fill_d  = fill_q;
        if (mode_chg) begin
            state_d = mode ? SLIDE : FR_MATCH;
            pos_d   = '0;
            alive_d = '0;
            shreg_d = '0;
            fill_d  = '0;
        end else if (in_valid) begin
            if (mode_q) begin
                state_d = SLIDE;
                shreg_d = window[W-2:0];
                if (!fill_full) begin
                    fill_d = fill_q + PW'(1);
                end
            end else if (last_bit) begin
                state_d = FR_MATCH;
                pos_d   = '0;
                alive_d = '0;
            end else begin
                state_d = (|survive) ? FR_MATCH : FR_FAIL;
                pos_d   = pos_q + PW'(1);
                alive_d = survive;
            end
        end
        // A slot rewritten mid-frame sits out the remainder of that frame.
        alive_d = alive_d & ~wr_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FR_MATCH;
            mode_q  <= 1'b0;
            pos_q   <= '0;
            alive_q <= '0;
            shreg_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode;
            pos_q   <= pos_d;
            alive_q <= alive_d;
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q <= '0;
            for (int i = 0; i < N; i++) begin
                pat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_mask[i]) begin
                    pat_q[i] <= cfg_pat;
                    en_q[i]  <= cfg_en;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            hit_cnt <= '0;
        end else if (dec && (hit_cnt != {CNT_W{1'b1}})) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_framed_seq_detector.sv
// Scoreboard bench for framed_seq_detector: a frame/window level reference
// model queues expected detects; a negedge monitor pops and compares them.
module tb_framed_seq_detector;

    localparam int W     = 4;
    localparam int N     = 3;
    localparam int CNT_W = 8;
    localparam int SAT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n, mode, in_valid, in_bit, cfg_we, cfg_en, cnt_clr;
    logic [1:0]       cfg_idx;
    logic [W-1:0]     cfg_pat;
    logic             dec, dec_s;
    logic [1:0]       dec_id, dec_id_s;
    logic [CNT_W-1:0] hit_cnt;
    logic [SAT_W-1:0] hit_cnt_s;

    always #5 clk = ~clk;

    framed_seq_detector #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in(in_bit),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_en(cfg_en),
        .cnt_clr(cnt_clr), .dec(dec), .dec_id(dec_id), .hit_cnt(hit_cnt)
    );

    framed_seq_detector #(.W(W), .N(N), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in(in_bit),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_en(cfg_en),
        .cnt_clr(cnt_clr), .dec(dec_s), .dec_id(dec_id_s), .hit_cnt(hit_cnt_s)
    );

    typedef struct {
        int cyc;
        int id;
        int cnt;
        int cnt_s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: frames are collected as integers and matched against
    // a snapshot of the slots taken at frame start; sliding keeps a bit queue.
    bit   m_mode_q;
    int   m_fcount, m_fval, m_cnt, m_cnt_s;
    int   m_pat[4], m_fpat[4];
    bit   m_en[4], m_fen[4], m_dirty[4];
    bit   m_hist[$];
    bit   cur_mode;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_cycle(input bit r, input bit m, input bit vld, input bit b,
                               input bit we, input int idx, input int p, input bit e,
                               input bit clr);
        bit hit;
        int hid;
        int val;
        hit = 1'b0;
        hid = 0;
        if (!r) begin
            m_mode_q = 1'b0;
            m_fcount = 0;
            m_hist.delete();
            m_cnt = 0;
            m_cnt_s = 0;
            for (int i = 0; i < 4; i++) begin
                m_pat[i] = 0;
                m_en[i] = 1'b0;
            end
            return;
        end
        if (m != m_mode_q) begin
            m_mode_q = m;
            m_fcount = 0;
            m_hist.delete();
        end else if (vld) begin
            if (m) begin
                if (m_hist.size() == W - 1) begin
                    val = 0;
                    foreach (m_hist[k]) val = val * 2 + int'(m_hist[k]);
                    val = val * 2 + int'(b);
                    for (int i = N - 1; i >= 0; i--)
                        if (m_en[i] && m_pat[i] == val) begin hit = 1'b1; hid = i; end
                end
                m_hist.push_back(b);
                if (m_hist.size() > W - 1) void'(m_hist.pop_front());
            end else begin
                if (m_fcount == 0) begin
                    for (int i = 0; i < N; i++) begin
                        m_fpat[i] = m_pat[i];
                        m_fen[i] = m_en[i];
                        m_dirty[i] = 1'b0;
                    end
                    m_fval = 0;
                end
                m_fval = m_fval * 2 + int'(b);
                m_fcount++;
                if (m_fcount == W) begin
                    for (int i = N - 1; i >= 0; i--)
                        if (m_fen[i] && !m_dirty[i] && m_fpat[i] == m_fval) begin
                            hit = 1'b1;
                            hid = i;
                        end
                    m_fcount = 0;
                end
            end
        end
        if (hit) exp_q.push_back('{cyc, hid, m_cnt, m_cnt_s});
        if (clr) begin
            m_cnt = 0;
            m_cnt_s = 0;
        end else if (hit) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_cnt_s < (1 << SAT_W) - 1) m_cnt_s++;
        end
        if (we && idx < N) begin
            m_pat[idx] = p;
            m_en[idx] = e;
            m_dirty[idx] = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit m, input bit vld, input bit b, input bit we,
                        input int idx, input int p, input bit e, input bit clr);
        cyc++;
        rst_n = r;
        mode = m;
        in_valid = vld;
        in_bit = b;
        cfg_we = we;
        cfg_idx = 2'(idx);
        cfg_pat = W'(p);
        cfg_en = e;
        cnt_clr = clr;
        model_cycle(r, m, vld, b, we, idx, p, e, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input bit m, input bit b);
        step(1'b1, m, 1'b1, b, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic gap(input bit m);
        step(1'b1, m, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input bit m, input int idx, input int p, input bit e);
        step(1'b1, m, 1'b0, 1'b0, 1'b1, idx, p, e, 1'b0);
    endtask

    task automatic frame(input bit m, input int val, input bit clr_last);
        for (int k = W - 1; k >= 0; k--)
            step(1'b1, m, 1'b1, 1'((val >> k) & 1), 1'b0, 0, 0, 1'b0, clr_last && (k == 0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (dec) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dec: got dec=1 id=%0d expected no detect (cycle %0d)",
                         dec_id, cyc);
            end else begin
                e = exp_q.pop_front();
                check("dec_cycle", cyc, e.cyc);
                check("dec_id", int'(dec_id), e.id);
                check("hit_cnt_at_dec", int'(hit_cnt), e.cnt);
                check("hit_cnt_sat_at_dec", int'(hit_cnt_s), e.cnt_s);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_dec: got dec=0 expected dec=1 id=%0d (cycle %0d)", e.id, e.cyc);
        end else begin
            check("dec_id_idle", int'(dec_id), 0);
        end
    end

    initial begin
        bit r, we;
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_we = 1'b0;
        cfg_idx = '0; cfg_pat = '0; cfg_en = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check("reset_hit_cnt", int'(hit_cnt), 0);
        check("reset_hit_cnt_sat", int'(hit_cnt_s), 0);

        // framed: three slots, one frame per slot plus a non-matching frame
        cfg(0, 0, 'b1001, 1'b1);
        cfg(0, 1, 'b0111, 1'b1);
        cfg(0, 2, 'b1110, 1'b1);
        frame(0, 'b1001, 1'b0);
        frame(0, 'b0111, 1'b0);
        frame(0, 'b1110, 1'b0);
        frame(0, 'b1111, 1'b0);
        gap(0);
        check("framed_hit_cnt", int'(hit_cnt), 3);
        check("framed_hit_cnt_sat", int'(hit_cnt_s), 3);

        // fail recovery, then write to a slot index beyond N (ignored)
        frame(0, 'b0100, 1'b0);
        frame(0, 'b1001, 1'b0);
        cfg(0, 3, 'b0100, 1'b1);
        frame(0, 'b0100, 1'b0);

        // sliding with only slot0, overlapping matches
        cfg(0, 1, 'b0111, 1'b0);
        cfg(0, 2, 'b1110, 1'b0);
        gap(1);
        bit_in(1, 1); bit_in(1, 0); bit_in(1, 0); bit_in(1, 1);
        bit_in(1, 0); bit_in(1, 0); bit_in(1, 1);
        gap(1);
        check("sliding_hit_cnt", int'(hit_cnt), 6);

        // framed with in_valid gaps between bits
        gap(0);
        bit_in(0, 1); repeat (3) gap(0);
        bit_in(0, 0); repeat (3) gap(0);
        bit_in(0, 0); repeat (3) gap(0);
        bit_in(0, 1);
        gap(0);
        check("gap_hit_cnt", int'(hit_cnt), 7);

        // mid-frame rewrite of slot0, next frame matches the new pattern
        bit_in(0, 1); bit_in(0, 0);
        cfg(0, 0, 'b0000, 1'b1);
        bit_in(0, 0); bit_in(0, 1);
        frame(0, 'b0000, 1'b0);
        bit_in(0, 0); bit_in(0, 0);
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("midframe_reset_hit_cnt", int'(hit_cnt), 0);

        // first frame after reset starts at pos 0; counter saturation
        cfg(0, 0, 'b1001, 1'b1);
        repeat (5) frame(0, 'b1001, 1'b0);
        gap(0);
        check("sat_hit_cnt_wide", int'(hit_cnt), 5);
        check("sat_hit_cnt_narrow", int'(hit_cnt_s), 3);
        frame(0, 'b1001, 1'b1);
        gap(0);
        check("clr_over_inc_wide", int'(hit_cnt), 0);
        check("clr_over_inc_narrow", int'(hit_cnt_s), 0);

        // randomized traffic
        cur_mode = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            r = ($urandom_range(0, 199) != 0);
            we = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) cur_mode = ~cur_mode;
            step(r, cur_mode, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), we,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, (1 << W) - 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        repeat (2) gap(cur_mode);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_hit_cnt", int'(hit_cnt), m_cnt);
        check("final_hit_cnt_sat", int'(hit_cnt_s), m_cnt_s);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
